dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/rv_mem_pkg.sv | 39 +++
 rtl/dmem_byte_ram.sv | 33 +++
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory responder: word geometry, FSM
// state encoding and the fault-reason codes produced by request decode.
package rv_mem_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef logic [1:0] fault_t;

    localparam fault_t FAULT_NONE     = 2'd0;
    localparam fault_t FAULT_MISALIGN = 2'd1;
    localparam fault_t FAULT_NO_BE    = 2'd2;
    localparam fault_t FAULT_RANGE    = 2'd3;

    // First matching reason wins; any non-NONE code means the request faults.
    function automatic fault_t fault_reason(
        input logic [XLEN-1:0] addr,
        input logic [BE_W-1:0] be,
        input logic [XLEN-1:0] depth_words
    );
        fault_t r;
        r = FAULT_NONE;
        if (addr[1:0] != 2'b00) begin
            r = FAULT_MISALIGN;
        end else if (be == '0) begin
            r = FAULT_NO_BE;
        end else if ({2'b00, addr[XLEN-1:2]} >= depth_words) begin
            r = FAULT_RANGE;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with per-byte-lane write enables and a registered read
// port. Contents are deliberately never reset.
module dmem_byte_ram
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic            clk,
    input  logic            we,
    input  logic            re,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [BE_W-1:0] be,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int lane = 0; lane < BE_W; lane++) begin
                if (be[lane]) begin
                    mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits a
// fixed number of cycles, commits or reads on entry to RESP, then holds the response.
module dmem_responder
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_be,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [1:0]  o_dbg_state
);

    // Request channel: a request transfers on a rising edge where
    // i_req_valid and o_req_ready are both 1. Response channel: a response
    // transfers on a rising edge where o_rsp_valid and i_rsp_ready are both 1;
    // until then o_rsp_rdata/o_rsp_err hold their values.

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q;
    logic            req_we_q;
    logic [XLEN-1:0] req_addr_q;
    logic [XLEN-1:0] req_wdata_q;
    logic [BE_W-1:0] req_be_q;
    logic            err_q;

    logic            accept;
    logic            enter_resp;
    logic            cur_we;
    logic [XLEN-1:0] cur_addr;
    logic [XLEN-1:0] cur_wdata;
    logic [BE_W-1:0] cur_be;
    fault_t          cur_fault;
    logic            cur_ok;
    logic            ram_we;
    logic            ram_re;
    logic [XLEN-1:0] ram_rdata;

    assign o_req_ready = (state_q == ST_IDLE) && i_rstn;
    assign accept      = i_req_valid && o_req_ready;

    // With no wait cycles the commit edge is the acceptance edge itself, so
    // decode must look at the live request rather than the captured copy.
    assign cur_we    = (state_q == ST_IDLE) ? i_req_we    : req_we_q;
    assign cur_addr  = (state_q == ST_IDLE) ? i_req_addr  : req_addr_q;
    assign cur_wdata = (state_q == ST_IDLE) ? i_req_wdata : req_wdata_q;
    assign cur_be    = (state_q == ST_IDLE) ? i_req_be    : req_be_q;
    assign cur_fault = fault_reason(cur_addr, cur_be, 32'(DEPTH_WORDS));
    assign cur_ok    = (cur_fault == FAULT_NONE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q       <= 4'd0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q       <= WAIT_LOAD;
                req_we_q    <= i_req_we;
                req_addr_q  <= i_req_addr;
                req_wdata_q <= i_req_wdata;
                req_be_q    <= i_req_be;
            end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp) begin
                err_q <= !cur_ok;
            end else if ((state_q == ST_RESP) && i_rsp_ready) begin
                err_q <= 1'b0;
            end
        end
    end

    assign ram_we = enter_resp && cur_we && cur_ok;
    assign ram_re = enter_resp && !cur_we && cur_ok;

    dmem_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (cur_addr[AW+1:2]),
        .wdata (cur_wdata),
        .be    (cur_be),
        .rdata (ram_rdata)
    );

    // The RAM read register is not reset, so gating here keeps rdata at zero
    // out of reset, for stores and for faults.
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rsp_err   = (state_q == ST_RESP) && err_q;
    assign o_rsp_rdata = ((state_q == ST_RESP) && !req_we_q && !err_q) ? ram_rdata : '0;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance driven with
// directed and random traffic against an array model, plus a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

    localparam int DEPTH  = 64;
    localparam int WAITC  = 2;
    localparam int DEPTH0 = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  dbg_state;

    logic        b_req_valid, b_req_we, b_rsp_ready;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_be;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic [1:0]  b_dbg_state;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_dbg_state(dbg_state)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rstn(rstn),
        .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_we(b_req_we),
        .i_req_addr(b_req_addr), .i_req_wdata(b_req_wdata), .i_req_be(b_req_be),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready),
        .o_rsp_rdata(b_rsp_rdata), .o_rsp_err(b_rsp_err), .o_dbg_state(b_dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mem_model [DEPTH];
    logic [31:0] model0 [DEPTH0];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic model_fault(input logic [31:0] addr, input logic [3:0] be, input int depth);
        return (addr[1:0] != 2'b00) || (be == 4'h0) || ((addr >> 2) >= 32'(depth));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Presents a request and returns at the first falling edge after it is
    // taken; the request bus is then filled with a junk valid store.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input string tag, output logic ok);
        int guard;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        rsp_ready = 1'b0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        ok = req_ready;
        if (!ok) begin
            check({tag, "_ready"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b1;
        req_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
        req_wdata = $urandom;
        req_be = 4'hF;
    endtask

    // Counts rising edges after the acceptance edge until the response shows.
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(WAITC));
    endtask

    task automatic finish_rsp(input int hold, input logic [31:0] exp_rd, input logic exp_err, input string tag);
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
            check({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
            check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input int hold, input string tag);
        logic ok, fault;
        logic [31:0] exp_rd;
        int lat, idx;
        fault  = model_fault(addr, be, DEPTH);
        idx    = int'(addr >> 2);
        exp_rd = 32'h0;
        if (!we && !fault) exp_rd = mem_model[idx];
        issue(we, addr, wd, be, tag, ok);
        if (!ok) return;
        wait_valid(tag, lat);
        if (!rsp_valid) begin
            req_valid = 1'b0;
            return;
        end
        if (we && !fault) mem_model[idx] = merge(mem_model[idx], wd, be);
        finish_rsp(hold, exp_rd, fault, tag);
    endtask

    initial begin
        logic ok;
        int lat, k, cyc, last, guard;
        logic [31:0] a, wd;
        logic [3:0] be;
        logic we;
        logic [31:0] st_data [4];

        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0; b_rsp_ready = 1'b0;

        #23;
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_err", 32'(rsp_err), 32'd0);
        check("reset_rdata", rsp_rdata, 32'h0);
        check("reset_state", 32'(dbg_state), 32'd0);
        check("reset0_valid", 32'(b_rsp_valid), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("reset_ready", 32'(req_ready), 32'd1);

        // Give every word a known value; word 8 (0x20) starts at zero.
        for (int i = 0; i < DEPTH; i++) begin
            transact(1'b1, 32'(i * 4), (i == 8) ? 32'h0 : $urandom, 4'hF, 0, "fill");
        end

        transact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st_full");
        transact(1'b0, 32'h10, 32'h0, 4'hF, 0, "ld_full");
        transact(1'b1, 32'h10, 32'h000000AA, 4'h1, 0, "st_lane0");
        transact(1'b0, 32'h10, 32'h0, 4'hF, 0, "ld_lane0");
        check("ld_lane0_value", mem_model[4], 32'hDEADBEAA);
        transact(1'b0, 32'h13, 32'h0, 4'hF, 0, "ld_misalign");
        transact(1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, 0, "st_range");
        transact(1'b0, 32'h0, 32'h0, 4'hF, 0, "ld_word0");
        transact(1'b1, 32'h18, 32'h12345678, 4'h0, 0, "st_no_be");
        transact(1'b0, 32'h18, 32'h0, 4'hF, 0, "ld_after_no_be");
        transact(1'b0, 32'h10, 32'h0, 4'hF, 5, "ld_hold");

        // Reset while the store to 0x20 is still waiting.
        issue(1'b1, 32'h20, 32'h55555555, 4'hF, "rst_wait", ok);
        if (ok) begin
            rstn = 1'b0;
            #1;
            check("rst_wait_valid", 32'(rsp_valid), 32'd0);
            check("rst_wait_err", 32'(rsp_err), 32'd0);
            check("rst_wait_rdata", rsp_rdata, 32'h0);
            check("rst_wait_state", 32'(dbg_state), 32'd0);
            req_valid = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
            #1;
            check("rst_wait_ready", 32'(req_ready), 32'd1);
        end
        transact(1'b0, 32'h20, 32'h0, 4'hF, 0, "rst_wait_load");

        // Reset while the store to 0x24 is already responding.
        issue(1'b1, 32'h24, 32'h12345678, 4'hF, "rst_resp", ok);
        if (ok) begin
            wait_valid("rst_resp", lat);
            if (rsp_valid) mem_model[9] = 32'h12345678;
            rstn = 1'b0;
            #1;
            check("rst_resp_valid", 32'(rsp_valid), 32'd0);
            req_valid = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
        end
        transact(1'b0, 32'h24, 32'h0, 4'hF, 0, "rst_resp_load");

        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, DEPTH - 1) * 4);
            wd = $urandom;
            be = 4'($urandom_range(1, 15));
            case ($urandom_range(0, 9))
                0: a = a + 32'($urandom_range(1, 3));
                1: a = 32'($urandom_range(DEPTH, DEPTH + 16) * 4);
                2: be = 4'h0;
                default: ;
            endcase
            transact(we, a, wd, be, int'($urandom_range(0, 3)), "rnd");
        end

        // No-wait instance with valid held high: stores to words 0..3, then loads back.
        for (int i = 0; i < 4; i++) st_data[i] = $urandom;
        b_rsp_ready = 1'b1;
        k = 0; cyc = 0; last = -1;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h0; b_req_wdata = st_data[0]; b_req_be = 4'hF;
        while (k < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (b_rsp_valid && exp_q.size() > 0) check("b2b_rdata", b_rsp_rdata, exp_q.pop_front());
            if (b_req_ready) begin
                if (k < 4) begin
                    model0[k] = st_data[k];
                    exp_q.push_back(32'h0);
                end else begin
                    exp_q.push_back(model0[k - 4]);
                end
                if (last >= 0) check("b2b_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                k++;
                @(posedge clk);
                #1;
                if (k < 4) begin
                    b_req_addr = 32'(k * 4); b_req_wdata = st_data[k];
                end else if (k < 8) begin
                    b_req_we = 1'b0; b_req_addr = 32'((k - 4) * 4); b_req_wdata = $urandom;
                end else begin
                    b_req_valid = 1'b0;
                end
            end
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
            if (b_rsp_valid) check("b2b_rdata", b_rsp_rdata, exp_q.pop_front());
        end
        check("b2b_accepts", 32'(k), 32'd8);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
